// File: rtl/sobel_pkg.sv
// Shared types and width helpers for the streaming Sobel edge detector.
package sobel_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } sobel_state_e;

  localparam int PIX_W_DEF = 8;
  localparam int MAG_W     = PIX_W_DEF + 3;

  function automatic int mag_width(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel-in / edge-flag-out stream handshake bundle for sobel_stream.
// out_mag exists only when SOBEL_MAG_OUT_EN is defined.
interface sobel_stream_if
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8
);
  localparam int LMAG_W = mag_width(PIX_W);

  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  data_in;
  logic [LMAG_W-1:0] thr;
  logic              out_valid;
  logic              out_ready;
  logic              data_out;
  logic              out_last;
`ifdef SOBEL_MAG_OUT_EN
  logic [LMAG_W-1:0] out_mag;
`endif

  modport master (
    output in_valid, data_in, thr, out_ready,
`ifdef SOBEL_MAG_OUT_EN
    input  out_mag,
`endif
    input  in_ready, out_valid, data_out, out_last
  );

  modport slave (
    input  in_valid, data_in, thr, out_ready,
`ifdef SOBEL_MAG_OUT_EN
    output out_mag,
`endif
    output in_ready, out_valid, data_out, out_last
  );

endinterface

// File: rtl/sobel_line_buf.sv
// One image line of pixel storage; combinational read and write share the
// column address, so the old value is read out as the new one is stored.
module sobel_line_buf #(
  parameter  int DEPTH = 160,
  parameter  int WIDTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, one edge flag per
// interior pixel out. Define SOBEL_MAG_OUT_EN to also export the magnitude.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int W     = 160,
  parameter int H     = 200,
  parameter int PIX_W = 8
) (
  input logic          clk,
  input logic          rstn,
  sobel_stream_if.slave s
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int MW = mag_width(PIX_W);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  sobel_state_e     r_state, w_state_nxt;
  logic             w_adv, w_xfer, w_emit;
  logic [PIX_W-1:0] w_lb1_rd, w_lb2_rd;
  logic [PIX_W-1:0] r_win [3][3];
  logic             r_s1_valid, r_s1_last;
  logic [MW-1:0]    r_s1_thr;
  logic [MW-1:0]    w_gx, w_gy, w_ax, w_ay, w_mag;
  logic             r_out_valid, r_data_out, r_out_last;

  // Every stage moves together; a stalled output freezes the whole pipe.
  assign w_adv  = !r_out_valid || s.out_ready;
  assign w_xfer = s.in_valid && w_adv;

  sobel_line_buf #(.DEPTH(W), .WIDTH(PIX_W)) u_lb1 (
    .clk(clk), .i_we(w_xfer), .i_addr(r_col), .i_wdata(s.data_in), .o_rdata(w_lb1_rd)
  );
  sobel_line_buf #(.DEPTH(W), .WIDTH(PIX_W)) u_lb2 (
    .clk(clk), .i_we(w_xfer), .i_addr(r_col), .i_wdata(w_lb1_rd), .o_rdata(w_lb2_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col   <= '0;
      r_row   <= '0;
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // state | meaning
  // FILL  | window not yet covering an interior centre; pixel yields no output
  // RUN   | row>=2 and col>=2; each accepted pixel yields one output
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      ST_FILL: if (w_xfer && r_row >= ROW_TWO && r_col == COL_ONE) w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_emit = w_xfer;
        if (w_xfer && r_col == COL_LAST) w_state_nxt = ST_FILL;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) r_win[i][j] <= '0;
      r_s1_thr   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      if (w_xfer) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= w_lb2_rd;
        r_win[1][2] <= w_lb1_rd;
        r_win[2][2] <= s.data_in;
        r_s1_thr    <= s.thr;
      end
      if (w_adv) begin
        r_s1_valid <= w_emit;
        r_s1_last  <= w_emit && r_row == ROW_LAST && r_col == COL_LAST;
      end
    end
  end

  function automatic logic [MW-1:0] wsum(input logic [PIX_W-1:0] a, b, c);
    return MW'(a) + (MW'(b) << 1) + MW'(c);
  endfunction

  // MW bits hold +/-4*max_pixel without wrap, so two's-complement differences suffice.
  assign w_gx  = wsum(r_win[0][2], r_win[1][2], r_win[2][2]) - wsum(r_win[0][0], r_win[1][0], r_win[2][0]);
  assign w_gy  = wsum(r_win[2][0], r_win[2][1], r_win[2][2]) - wsum(r_win[0][0], r_win[0][1], r_win[0][2]);
  assign w_ax  = w_gx[MW-1] ? (~w_gx + 1'b1) : w_gx;
  assign w_ay  = w_gy[MW-1] ? (~w_gy + 1'b1) : w_gy;
  assign w_mag = w_ax + w_ay;

`ifdef SOBEL_MAG_OUT_EN
  logic [MW-1:0] r_out_mag;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_out_mag <= '0;
    else if (w_adv) r_out_mag <= w_mag;
  end
  assign s.out_mag = r_out_mag;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_data_out  <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      r_data_out  <= r_s1_valid && (w_mag > r_s1_thr);
      r_out_last  <= r_s1_last;
    end
  end

  assign s.in_ready  = w_adv;
  assign s.out_valid = r_out_valid;
  assign s.data_out  = r_data_out;
  assign s.out_last  = r_out_last;

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on a 5x4 frame against a direct
// Sobel formula model.
module tb_sobel_stream;

  localparam int W = 5, H = 4, PIX_W = 8;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sobel_stream_if #(.PIX_W(PIX_W)) bus ();
  sobel_stream #(.W(W), .H(H), .PIX_W(PIX_W)) dut (.clk(clk), .rstn(rstn), .s(bus));

  int checks = 0, errors = 0, cyc = 0;
  int stim[$], stim_thr[$], acc_cyc[$], got_c[$];
  bit got_e[$], got_l[$], exp_e[$], exp_l[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rstn && bus.out_valid && bus.out_ready) begin
      got_e.push_back(bus.data_out);
      got_l.push_back(bus.out_last);
      got_c.push_back(cyc);
    end

  task automatic clear_all();
    stim.delete(); stim_thr.delete(); acc_cyc.delete();
    got_e.delete(); got_l.delete(); got_c.delete();
    exp_e.delete(); exp_l.delete();
  endtask

  // kind: 0 flat 100, 1 vertical step, 2 checkerboard 0/255, 3 random
  task automatic gen_frame(input int kind, input int thr);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case (kind)
          0: stim.push_back(100);
          1: stim.push_back(c < 2 ? 0 : 200);
          2: stim.push_back(((r + c) % 2) ? 255 : 0);
          default: stim.push_back($urandom_range(255));
        endcase
        stim_thr.push_back(thr);
      end
  endtask

  task automatic model_frame(input int base);
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        int p[3][3];
        int gx, gy, mag;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++) p[dr][dc] = stim[base + (r - 1 + dr) * W + (c - 1 + dc)];
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        exp_e.push_back(mag > stim_thr[base + (r + 1) * W + (c + 1)]);
        exp_l.push_back(r == H - 2 && c == W - 2);
      end
  endtask

  task automatic send_pixels(input bit gaps);
    int idx = 0, guard = 0;
    while (idx < stim.size() && guard < 5000) begin
      @(posedge clk); #1;
      if (gaps && $urandom_range(3) == 0) bus.in_valid = 1'b0;
      else begin
        bus.in_valid = 1'b1;
        bus.data_in  = PIX_W'(stim[idx]);
        bus.thr      = 11'(stim_thr[idx]);
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc.push_back(cyc + 1);
        idx++;
      end
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (idx != stim.size()) begin
      errors++;
      $display("FAIL send_timeout: accepted %0d pixels, required %0d", idx, stim.size());
    end
  endtask

  task automatic drain();
    int n = 0;
    while (got_e.size() < exp_e.size() && n < 100) begin
      @(negedge clk); n++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid/data/last %b%b%b, required 000", bus.out_valid, bus.data_out, bus.out_last);
    end
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_flat();
    clear_all(); gen_frame(0, 0); model_frame(0);
    send_pixels(1'b1); drain();
    checks++;
    if (got_e.size() != 6) begin
      errors++; $display("FAIL flat_count: got %0d outputs, required 6", got_e.size());
    end
    for (int i = 0; i < got_e.size() && i < 6; i++) begin
      checks++;
      if (got_e[i] !== 1'b0 || got_l[i] !== (i == 5)) begin
        errors++; $display("FAIL flat_out[%0d]: edge/last %b/%b, required 0/%b", i, got_e[i], got_l[i], i == 5);
      end
    end
  endtask

  task automatic test_step();
    bit pat[3];
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0;
    clear_all(); gen_frame(1, 400); model_frame(0);
    send_pixels(1'b1); drain();
    checks++;
    if (got_e.size() != 6) begin
      errors++; $display("FAIL step_count: got %0d outputs, required 6", got_e.size());
    end
    for (int i = 0; i < got_e.size() && i < 6; i++) begin
      checks++;
      if (got_e[i] !== pat[i % 3] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL step_out[%0d]: edge/last %b/%b, required %b/%b", i, got_e[i], got_l[i], pat[i % 3], exp_l[i]);
      end
    end
  endtask

  task automatic test_stall();
    clear_all(); gen_frame(3, $urandom_range(1200)); model_frame(0);
    fork
      send_pixels(1'b0);
      begin
        int n = 0;
        bit done = 1'b0, hv_e, hv_l;
        while (!done && n < 300) begin
          @(posedge clk); #1; n++;
          if (bus.out_valid && got_e.size() >= 2) done = 1'b1;
        end
        checks++;
        if (!done) begin
          errors++; $display("FAIL stall_trigger: no mid-frame output seen, required one");
        end else begin
          bus.out_ready = 1'b0;
          hv_e = bus.data_out; hv_l = bus.out_last;
          repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.data_out !== hv_e || bus.out_last !== hv_l) begin
              errors++;
              $display("FAIL stall_hold: in_ready/valid/data/last %b%b%b%b, required 01%b%b",
                       bus.in_ready, bus.out_valid, bus.data_out, bus.out_last, hv_e, hv_l);
            end
          end
          @(posedge clk); #1 bus.out_ready = 1'b1;
        end
      end
    join
    drain();
    checks++;
    if (got_e.size() != exp_e.size()) begin
      errors++; $display("FAIL stall_count: got %0d outputs, required %0d", got_e.size(), exp_e.size());
    end
    for (int i = 0; i < got_e.size() && i < exp_e.size(); i++) begin
      checks++;
      if (got_e[i] !== exp_e[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL stall_out[%0d]: edge/last %b/%b, required %b/%b", i, got_e[i], got_l[i], exp_e[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_thr();
    clear_all(); gen_frame(2, 2047);
    send_pixels(1'b1); drain();
    checks++;
    if (got_e.size() != 6) begin
      errors++; $display("FAIL thr_max_count: got %0d outputs, required 6", got_e.size());
    end
    foreach (got_e[i]) begin
      checks++;
      if (got_e[i] !== 1'b0) begin
        errors++; $display("FAIL thr_max_out[%0d]: edge %b, required 0", i, got_e[i]);
      end
    end
    clear_all(); gen_frame(3, 0); model_frame(0);
    send_pixels(1'b1); drain();
    checks++;
    if (got_e.size() != exp_e.size()) begin
      errors++; $display("FAIL thr_zero_count: got %0d outputs, required %0d", got_e.size(), exp_e.size());
    end
    for (int i = 0; i < got_e.size() && i < exp_e.size(); i++) begin
      checks++;
      if (got_e[i] !== exp_e[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL thr_zero_out[%0d]: edge/last %b/%b, required %b/%b", i, got_e[i], got_l[i], exp_e[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_all();
    for (int i = 0; i < 7; i++) begin
      stim.push_back($urandom_range(255)); stim_thr.push_back(0);
    end
    send_pixels(1'b0);
    @(posedge clk); #1 rstn = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_mid_valid: out_valid %b during reset, required 0", bus.out_valid);
      end
    end
    @(posedge clk); #1 rstn = 1'b1;
    clear_all(); gen_frame(3, $urandom_range(800)); model_frame(0);
    send_pixels(1'b1); drain();
    checks++;
    if (got_e.size() != exp_e.size()) begin
      errors++; $display("FAIL rst_mid_count: got %0d outputs, required %0d", got_e.size(), exp_e.size());
    end
    for (int i = 0; i < got_e.size() && i < exp_e.size(); i++) begin
      checks++;
      if (got_e[i] !== exp_e[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL rst_mid_out[%0d]: edge/last %b/%b, required %b/%b", i, got_e[i], got_l[i], exp_e[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    gen_frame(3, $urandom_range(900)); gen_frame(3, $urandom_range(900));
    model_frame(0); model_frame(NPIX);
    send_pixels(1'b0); drain();
    checks++;
    if (got_e.size() != 12) begin
      errors++; $display("FAIL b2b_count: got %0d outputs, required 12", got_e.size());
    end
    for (int i = 0; i < got_e.size() && i < 12; i++) begin
      checks++;
      if (got_e[i] !== exp_e[i] || got_l[i] !== (i == 5 || i == 11)) begin
        errors++; $display("FAIL b2b_out[%0d]: edge/last %b/%b, required %b/%b", i, got_e[i], got_l[i], exp_e[i], i == 5 || i == 11);
      end
    end
    if (got_c.size() >= 7 && acc_cyc.size() == 2 * NPIX) begin
      checks++;
      if (got_c[0] != acc_cyc[2 * W + 2] + 1 || got_c[6] != acc_cyc[NPIX + 2 * W + 2] + 1) begin
        errors++;
        $display("FAIL b2b_latency: outputs at cycles %0d/%0d, required %0d/%0d",
                 got_c[0], got_c[6], acc_cyc[2 * W + 2] + 1, acc_cyc[NPIX + 2 * W + 2] + 1);
      end
    end else begin
      checks++; errors++;
      $display("FAIL b2b_latency: %0d outputs and %0d accepted pixels, required >=7 and %0d", got_c.size(), acc_cyc.size(), 2 * NPIX);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.thr       = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_flat();
    test_step();
    test_stall();
    test_thr();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
